// File: rtl/pulse_count_handoff.sv
// pulse_count_handoff
// Fast-domain event aggregator feeding a fast-to-slow pulse synchronizer.
// It counts event pulses into an accumulator, freezes the count into a
// hold register, fires a one-cycle request, and waits for the
// synchronizer's completion before it launches the next batch. This keeps
// the count the slow side samples stable for the whole crossing.
//
// Parameters
//   W        accumulator / hold register width
//   TMO      maximum WAIT cycles before abort (>= 1)
// Ports
//   ckf      fast clock, rising edge
//   resetnf  asynchronous active-low reset
//   en       event counting enable
//   evt      event pulse, one count per high cycle
//   clr      synchronous clear of the sticky flags (a same-cycle set wins)
//   donef    single-cycle completion from the synchronizer
//   pulsef   registered single-cycle request to the synchronizer
//   cnt_hold frozen batch count, stable from pulsef until the next launch
//   busy     high while waiting for donef
//   ovf      sticky: an increment was lost to saturation
//   tmo_err  sticky: a WAIT was aborted by timeout
`timescale 1ns/1ps
module pulse_count_handoff #(
   parameter int unsigned W   = 16,
   parameter int unsigned TMO = 1023
) (
   input  logic         ckf,
   input  logic         resetnf,
   input  logic         en,
   input  logic         evt,
   input  logic         clr,
   input  logic         donef,
   output logic         pulsef,
   output logic [W-1:0] cnt_hold,
   output logic         busy,
   output logic         ovf,
   output logic         tmo_err
);

   localparam int unsigned TW = $clog2(TMO + 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [W-1:0]    hold_q, hold_d;
   logic            pulse_q, pulse_d;
   logic            ovf_q, ovf_d;
   logic            tmo_q, tmo_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;

   logic            inc;
   logic            acc_sat;
   logic            set_ovf;
   logic            set_tmo;

   assign inc     = en & evt;
   assign acc_sat = (acc_q == {W{1'b1}});

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      hold_d  = hold_q;
      pulse_d = 1'b0;
      tcnt_d  = tcnt_q;
      set_ovf = 1'b0;
      set_tmo = 1'b0;

      // Default accumulate with saturation; a lost increment is an overflow.
      if (inc) begin
         if (acc_sat) set_ovf = 1'b1;
         else         acc_d   = acc_q + W'(1);
      end

      case (state_q)
         IDLE: begin
            if (acc_q != '0) begin
               // Launch: a same-cycle event starts the next batch, so
               // nothing is lost and no overflow applies here.
               hold_d  = acc_q;
               acc_d   = inc ? W'(1) : '0;
               set_ovf = 1'b0;
               pulse_d = 1'b1;
               tcnt_d  = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            tcnt_d = tcnt_q + TW'(1);
            // Completion beats timeout when both land on the same cycle.
            if (donef) begin
               state_d = IDLE;
            end else if (tcnt_q == TW'(TMO - 1)) begin
               set_tmo = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      ovf_d = set_ovf | (ovf_q & ~clr);
      tmo_d = set_tmo | (tmo_q & ~clr);
   end

   always_ff @(posedge ckf or negedge resetnf) begin
      if (!resetnf) begin
         state_q <= IDLE;
         acc_q   <= '0;
         hold_q  <= '0;
         pulse_q <= 1'b0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         hold_q  <= hold_d;
         pulse_q <= pulse_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign pulsef   = pulse_q;
   assign cnt_hold = hold_q;
   assign busy     = (state_q == WAIT);
   assign ovf      = ovf_q;
   assign tmo_err  = tmo_q;

endmodule

// File: tb/tb_pulse_count_handoff.sv
// Directed bench for pulse_count_handoff (W=4, TMO=32). Expected batch
// counts are queued as stimulus is driven and checked whenever pulsef fires.
`timescale 1ns/1ps
module tb_pulse_count_handoff;

   localparam int unsigned W   = 4;
   localparam int unsigned TMO = 32;

   logic         ckf = 1'b0;
   logic         resetnf;
   logic         en, evt, clr, donef;
   logic         pulsef;
   logic [W-1:0] cnt_hold;
   logic         busy, ovf, tmo_err;

   int n_cmp = 0;
   int n_mis = 0;
   int npulse = 0;
   int sum_hold = 0;
   logic prev_pulse = 1'b0;
   logic [W-1:0] exp_q[$];

   pulse_count_handoff #(.W(W), .TMO(TMO)) dut (
      .ckf(ckf), .resetnf(resetnf), .en(en), .evt(evt), .clr(clr),
      .donef(donef), .pulsef(pulsef), .cnt_hold(cnt_hold), .busy(busy),
      .ovf(ovf), .tmo_err(tmo_err)
   );

   always #5 ckf = ~ckf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge ckf);
      #1;
   endtask

   // Scoreboard: every request pulse pops one expected batch count.
   always @(posedge ckf) begin
      #1;
      if (pulsef === 1'b1) begin
         npulse++;
         sum_hold += int'(cnt_hold);
         chk("pulse_gap", {31'd0, prev_pulse}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_pulse", 32'd1, 32'd0);
         end else begin
            chk("sb_cnt_hold", {28'd0, cnt_hold}, {28'd0, exp_q.pop_front()});
         end
      end
      prev_pulse = pulsef;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int np0, sum0, since, bcnt;
      resetnf = 1'b0; en = 1'b1; evt = 1'b0; clr = 1'b0; donef = 1'b0;

      // Reset state
      cyc(); cyc();
      chk("reset_outs", {27'd0, pulsef, busy, ovf, tmo_err, 1'b0}, 32'd0);
      chk("reset_hold", {28'd0, cnt_hold}, 32'd0);
      resetnf = 1'b1;
      cyc(); cyc();
      chk("idle_no_pulse", {31'd0, pulsef}, 32'd0);

      // Single batch: a one-count batch, then 3 events while waiting
      evt = 1'b1; exp_q.push_back(4'd1); cyc();
      evt = 1'b0; cyc();
      chk("first_busy", {31'd0, busy}, 32'd1);
      evt = 1'b1; cyc(); cyc(); cyc(); evt = 1'b0;
      donef = 1'b1; cyc(); donef = 1'b0;
      chk("done_idle", {31'd0, busy}, 32'd0);
      exp_q.push_back(4'd3); np0 = npulse;
      cyc();
      chk("batch3_busy0", {31'd0, busy}, 32'd1);
      repeat (3) begin cyc(); chk("batch3_busy", {31'd0, busy}, 32'd1); end
      donef = 1'b1; cyc(); donef = 1'b0;
      chk("batch3_end", {30'd0, busy, pulsef}, 32'd0);
      repeat (5) cyc();
      chk("batch3_one_pulse", npulse - np0, 32'd1);

      // Back-to-back: evt every cycle for 40 cycles, donef 6 cycles after each pulse
      foreach (exp_q[i]) ;
      exp_q.push_back(4'd1);
      repeat (5) exp_q.push_back(4'd7);
      exp_q.push_back(4'd4);
      sum0 = sum_hold; since = 99;
      evt = 1'b1;
      for (int i = 0; i < 70; i++) begin
         cyc();
         if (i == 39) evt = 1'b0;
         if (pulsef) since = 0; else since++;
         donef = (since == 5);
      end
      donef = 1'b0;
      chk("b2b_sum", sum_hold - sum0, 32'd40);
      chk("b2b_idle", {31'd0, busy}, 32'd0);

      // Saturation: 20 events while waiting saturates the 4-bit accumulator
      evt = 1'b1; exp_q.push_back(4'd1); cyc();
      evt = 1'b0; cyc();
      evt = 1'b1; repeat (20) cyc(); evt = 1'b0;
      chk("sat_ovf", {31'd0, ovf}, 32'd1);
      chk("sat_no_tmo", {31'd0, tmo_err}, 32'd0);
      exp_q.push_back(4'd15);
      donef = 1'b1; cyc(); donef = 1'b0;
      cyc();
      chk("sat_launch", {31'd0, pulsef}, 32'd1);
      chk("sat_ovf_sticky", {31'd0, ovf}, 32'd1);
      clr = 1'b1; cyc(); clr = 1'b0;
      chk("sat_clr", {31'd0, ovf}, 32'd0);
      donef = 1'b1; cyc(); donef = 1'b0;

      // Timeout: no donef, one event arrives during the WAIT
      evt = 1'b1; exp_q.push_back(4'd1); cyc();
      evt = 1'b0; exp_q.push_back(4'd1); cyc();
      bcnt = 1; evt = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cyc();
         evt = 1'b0;
         if (!busy) break;
         bcnt++;
      end
      chk("tmo_busy_cycles", bcnt, TMO);
      chk("tmo_err_set", {31'd0, tmo_err}, 32'd1);
      cyc();
      chk("tmo_relaunch", {30'd0, pulsef, busy}, 32'd3);
      donef = 1'b1; cyc(); donef = 1'b0;
      clr = 1'b1; cyc(); clr = 1'b0;
      chk("tmo_clr", {31'd0, tmo_err}, 32'd0);

      // donef on the timeout cycle wins
      evt = 1'b1; exp_q.push_back(4'd1); cyc();
      evt = 1'b0; cyc();
      repeat (31) cyc();
      chk("prio_still_busy", {31'd0, busy}, 32'd1);
      donef = 1'b1; cyc(); donef = 1'b0;
      chk("prio_idle", {31'd0, busy}, 32'd0);
      chk("prio_no_tmo", {31'd0, tmo_err}, 32'd0);

      // donef in IDLE is ignored
      donef = 1'b1; cyc(); donef = 1'b0;
      chk("idle_donef", {30'd0, busy, pulsef}, 32'd0);

      // clr and an overflow on the same cycle: the set wins
      evt = 1'b1; exp_q.push_back(4'd1); cyc();
      evt = 1'b0; cyc();
      evt = 1'b1; repeat (15) cyc();
      chk("fill_no_ovf", {31'd0, ovf}, 32'd0);
      clr = 1'b1; cyc(); clr = 1'b0; evt = 1'b0;
      chk("clr_vs_set", {31'd0, ovf}, 32'd1);
      exp_q.push_back(4'd15);
      donef = 1'b1; cyc(); donef = 1'b0;
      cyc();
      donef = 1'b1; cyc(); donef = 1'b0;
      clr = 1'b1; cyc(); clr = 1'b0;

      // Reset mid-WAIT with acc=5 discards the batch
      evt = 1'b1; exp_q.push_back(4'd1); cyc();
      evt = 1'b0; cyc();
      evt = 1'b1; repeat (5) cyc(); evt = 1'b0;
      chk("rst_pre_busy", {31'd0, busy}, 32'd1);
      #2 resetnf = 1'b0;
      #1;
      chk("rst_async_outs", {27'd0, pulsef, busy, ovf, tmo_err, 1'b0}, 32'd0);
      chk("rst_async_hold", {28'd0, cnt_hold}, 32'd0);
      cyc(); cyc();
      resetnf = 1'b1; np0 = npulse;
      repeat (4) cyc();
      chk("rst_no_pulse", npulse - np0, 32'd0);
      evt = 1'b1; exp_q.push_back(4'd1); cyc();
      evt = 1'b0; cyc();
      chk("rst_new_launch", {31'd0, pulsef}, 32'd1);
      donef = 1'b1; cyc(); donef = 1'b0;
      cyc();

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
